// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - byte/half/word load-store initiator over a 32-bit word memory
// Optional MISALIGN_CHK_EN rejects misaligned half/word accesses with err.
module lsu_mem_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_WE,
  input  logic [31:0]       mem_RD
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state, state_nx;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wd_q;
  logic              err_q;
  logic              bad;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_val;
  logic [31:0]       merged;

  always_comb begin
    bad = we ? (funct3[2] || funct3 == 3'b011)
             : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
`ifdef MISALIGN_CHK_EN
    if (funct3[1:0] == 2'b01 && addr[0])          bad = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad)                           state_nx = DONE;
          else if (we && funct3 == 3'b010)   state_nx = WRITE;
          else                               state_nx = READ;
        end
      end
      READ:    state_nx = we_q ? WRITE : DONE;
      WRITE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane extraction and sub-word merge both work on the word read in READ.
  always_comb begin
    byte_sel = mem_RD[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
    case (f3_q[1:0])
      2'b00:   load_val = f3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = f3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = mem_RD;
    endcase
    merged = mem_RD;
    if (f3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wd_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wd_q[15:0];
    end else begin
      merged[15:0] = wd_q[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      f3_q   <= 3'b000;
      addr_q <= '0;
      wd_q   <= 32'h0;
      err_q  <= 1'b0;
      rdata  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q   <= we;
            f3_q   <= funct3;
            addr_q <= addr;
            err_q  <= bad;
            if (we) wd_q <= wdata;
          end
        end
        READ: begin
          if (we_q) wd_q  <= merged;
          else      rdata <= load_val;
        end
        default: ;
      endcase
    end
  end

  assign ready  = (state == IDLE);
  assign done   = (state == DONE);
  assign err    = (state == DONE) && err_q;
  assign mem_A  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_WD = wd_q;
  assign mem_WE = (state == WRITE);

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed self-checking bench for lsu_mem_master
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ready, done, err;
  logic [31:0] rdata, mem_A, mem_WD, mem_RD;
  logic        mem_WE;

  logic [31:0] mem [0:15];
  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  logic [31:0] we_addr = 32'h0;
  int          lat;
  logic        e;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE),
    .mem_RD(mem_RD)
  );

  assign mem_RD = mem[mem_A[5:2]];

  always @(posedge clk) if (mem_WE) mem[mem_A[5:2]] <= mem_WD;

  always @(negedge clk) if (mem_WE) begin
    we_cnt  = we_cnt + 1;
    we_addr = mem_A;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one request; returns edges from E0 to the done cycle (99 on timeout).
  task automatic do_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int l, output logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 10) begin @(negedge clk); n++; end
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    l = 99; eo = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin l = i; eo = err; break; end
      @(posedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    mem[2] = 32'h80FF7F01;
    #12;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_A", mem_A, 32'h0);
    chk("rst_mem_WD", mem_WD, 32'h0);
    chk("rst_mem_WE", {31'b0, mem_WE}, 32'd0);
    rst_n = 1'b1;

    do_op(1'b0, 3'b000, 32'h9, 32'h0, lat, e);
    chk("lb9_lat", lat, 1); chk("lb9_data", rdata, 32'h0000007F); chk("lb9_err", {31'b0, e}, 0);
    do_op(1'b0, 3'b000, 32'hA, 32'h0, lat, e);
    chk("lbA_data", rdata, 32'hFFFFFFFF);
    do_op(1'b0, 3'b100, 32'hB, 32'h0, lat, e);
    chk("lbuB_data", rdata, 32'h00000080);
    do_op(1'b0, 3'b101, 32'hA, 32'h0, lat, e);
    chk("lhuA_data", rdata, 32'h000080FF);
    do_op(1'b0, 3'b001, 32'hA, 32'h0, lat, e);
    chk("lhA_data", rdata, 32'hFFFF80FF);
    do_op(1'b0, 3'b001, 32'h8, 32'h0, lat, e);
    chk("lh8_data", rdata, 32'h00007F01);
    do_op(1'b0, 3'b010, 32'h8, 32'h0, lat, e);
    chk("lw8_lat", lat, 1); chk("lw8_data", rdata, 32'h80FF7F01);

    we_cnt = 0;
    do_op(1'b1, 3'b000, 32'hB, 32'h123456AB, lat, e);
    chk("sb_lat", lat, 2); chk("sb_wecnt", we_cnt, 1); chk("sb_word", mem[2], 32'hABFF7F01);
    chk("sb_rdata_held", rdata, 32'h80FF7F01);
    we_cnt = 0;
    do_op(1'b1, 3'b001, 32'h8, 32'h0000BEEF, lat, e);
    chk("sh_lat", lat, 2); chk("sh_wecnt", we_cnt, 1); chk("sh_word", mem[2], 32'hABFFBEEF);

    // sw with a competing load held high from the WRITE cycle on.
    we_cnt = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    chk("sw_we_in_write", {31'b0, mem_WE}, 32'd1);
    we = 1'b0; funct3 = 3'b010; addr = 32'h10;
    @(negedge clk);
    chk("sw_done", {31'b0, done}, 32'd1);
    chk("sw_ready_in_done", {31'b0, ready}, 32'd0);
    chk("sw_wecnt", we_cnt, 1); chk("sw_weaddr", we_addr, 32'h10);
    chk("sw_word", mem[4], 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_ready_back", {31'b0, ready}, 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
    lat = 99;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin lat = i; break; end
      @(posedge clk);
    end
    chk("held_req_lat", lat, 1); chk("held_req_data", rdata, 32'hDEADBEEF);
    chk("held_req_wecnt", we_cnt, 1);

    we_cnt = 0;
    do_op(1'b0, 3'b010, 32'h6, 32'h0, lat, e);
`ifdef MISALIGN_CHK_EN
    chk("mis_lat", lat, 0); chk("mis_err", {31'b0, e}, 1); chk("mis_rdata", rdata, 32'hDEADBEEF);
`else
    chk("mis_lat", lat, 1); chk("mis_err", {31'b0, e}, 0); chk("mis_rdata", rdata, 32'h55667788);
`endif
    chk("mis_wecnt", we_cnt, 0);
    do_op(1'b0, 3'b011, 32'h8, 32'h0, lat, e);
    chk("bad_f3_lat", lat, 0); chk("bad_f3_err", {31'b0, e}, 1);
    do_op(1'b1, 3'b100, 32'h8, 32'hFFFFFFFF, lat, e);
    chk("bad_st_err", {31'b0, e}, 1); chk("bad_st_wecnt", we_cnt, 0);
    chk("bad_st_word", mem[2], 32'hABFFBEEF);

    // Reset during the READ of a sub-word store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b001; addr = 32'h2; wdata = 32'h0000CAFE;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_we", {31'b0, mem_WE}, 32'd0);
    chk("rstmid_ready", {31'b0, ready}, 32'd1);
    chk("rstmid_done", {31'b0, done}, 32'd0);
    chk("rstmid_rdata", rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_word", mem[0], 32'h11223344);
    chk("rstmid_wecnt", we_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that sits between the single-cycle RISC-V datapath and the word-addressed data memory. It accepts one byte, halfword or word load/store request at a time. On the memory side it drives a 32-bit word interface: combinational read, write on the clock edge. Loads are sign- or zero-extended. Sub-word stores are done as read-modify-write, so the memory only ever sees full-word writes.

## Interface
Parameters:
- ADDR_W, 32, byte address width on both sides.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only while ready=1.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V width code. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data; low byte/half used for sb/sh.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; request rejected, no memory write.
- rdata  out  32  extended load data; held until the next successful load.
- mem_A  out  ADDR_W  word-aligned byte address to memory ({addr[31:2],2'b00}).
- mem_WD  out  32  write word.
- mem_WE  out  1  write enable.
- mem_RD  in  32  combinational read word for mem_A.

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- **IDLE**
  - req=1 latches we, funct3, addr and wdata.
  - Invalid code or misaligned access (see Configuration): go to DONE with err flagged.
  - Load or sb/sh: go to READ.
  - sw: go to WRITE.
- **READ**
  - Drives mem_A and samples mem_RD at the edge.
  - Load: the selected lane is extended into rdata, then go to DONE.
  - Lane select: byte = addr[1:0]; half = addr[1] (0 = bits 15:0, 1 = bits 31:16).
  - Extension: lb/lh sign-extend; lbu/lhu zero-extend.
  - sb/sh: the new byte/half is merged into the read word in the selected lane, the merged word is registered, then go to WRITE.
- **WRITE**
  - mem_WE=1 and mem_WD = merged word (sb/sh) or wdata (sw) for exactly this cycle; the memory captures at the edge.
  - Next state: DONE.
- **DONE**
  - done=1 and err as flagged; next state: IDLE.
  - Requests outside IDLE are ignored; the requester must hold or re-present req.
- **Invalid codes**
  - Invalid funct3: load 011/110/111, store 011 or 1xx.
  - Response: err=1, no memory access, rdata unchanged.
- **Reset values:** state IDLE, ready=1, done=0, err=0, rdata=0, mem_A=0, mem_WD=0, mem_WE=0.
- **Reset mid-operation:** mem_WE drops immediately. A sub-word store interrupted before WRITE leaves memory unmodified.

## Timing
- E0 is the accepting edge.
- **Latency** (done high in the cycle after the listed edge):
  - Load: READ in the E0→E1 cycle; done after E1.
  - sw: WRITE in the E0→E1 cycle; done after E1.
  - sb/sh: READ E0→E1, WRITE E1→E2; done after E2.
  - Error: DONE directly; done after E0.
- **Throughput:** ready returns high the cycle after done. Minimum request spacing is 3 cycles (load/sw) or 4 cycles (sb/sh).
- **Memory-side outputs:** mem_WE is a decode of state==WRITE. mem_A is stable for the entire READ and WRITE span of a request.

## Configuration
- MISALIGN_CHK_EN defined:
  - lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]≠00, completes via DONE with err=1.
  - No memory access; rdata unchanged.
- Not defined:
  - Unused low address bits are ignored: halfwords use addr[1] only, words use the full aligned word.
  - err is raised only for invalid funct3.

## Test plan
- Word 0x8 = 0x80FF7F01; lb addr 0x9 -> rdata=0x0000007F, done after E1; lb addr 0xA -> rdata=0xFFFFFFFF.
- Same word; lhu addr 0xA -> 0x000080FF; lh addr 0xA -> 0xFFFF80FF; lw addr 0x8 -> 0x80FF7F01.
- sb wdata=0x123456AB addr 0xB -> one mem_WE pulse at E1→E2, word becomes 0xABFF7F01, done after E2. Then sh wdata=0xBEEF addr 0x8 -> word 0xABFFBEEF.
- sw 0xDEADBEEF addr 0x10 -> mem_WE high exactly one cycle with mem_A=0x10; a req asserted during WRITE is ignored and is accepted only after ready returns.
- MISALIGN_CHK_EN: lw addr 0x6 -> done+err after E0, mem_WE never high, rdata unchanged. Without the macro, the same request reads word 0x4 with err=0. funct3=011 load -> err=1 in both builds.
- Assert rst_n=0 during the READ of sh addr 0x2 -> mem_WE stays 0, target word unchanged, ready=1 and done=0 immediately.
